// File: rtl/pipe_stage_buf.sv
// Elastic DEPTH-entry buffer between two core pipeline stages, with synchronous flush.
// Optional zero-latency empty-buffer bypass is enabled by defining PIPE_BUF_BYPASS_EN.
module pipe_stage_buf #(
    parameter int BUS_W = 64,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [BUS_W-1:0] in_bus,
    output logic             in_allowin,
    output logic             out_valid,
    output logic [BUS_W-1:0] out_bus,
    input  logic             out_allowin,
    input  logic             flush,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [BUS_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             held_valid;
    logic             push;
    logic             pop;
    logic             wr_en;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign held_valid = (count_q != '0);
    assign in_allowin = (count_q < FULL_CNT) | out_allowin;
    assign push       = in_valid & in_allowin & ~flush;
    assign pop        = held_valid & out_allowin & ~flush;
    assign count      = count_q;

`ifdef PIPE_BUF_BYPASS_EN
    logic bypass;

    // An entry offered to an empty buffer is presented immediately; it is only
    // stored if downstream does not take it this cycle.
    assign bypass    = ~held_valid & in_valid & ~flush;
    assign out_valid = held_valid | bypass;
    assign out_bus   = bypass ? in_bus : mem_q[rd_ptr_q];
    assign wr_en     = push & ~(bypass & out_allowin);
`else
    assign out_valid = held_valid;
    assign out_bus   = mem_q[rd_ptr_q];
    assign wr_en     = push;
`endif

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = next_ptr(wr_ptr_q);
            if (pop)   rd_ptr_d = next_ptr(rd_ptr_q);
            case ({wr_en, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (wr_en) mem_q[wr_ptr_q] <= in_bus;
        end
    end

endmodule
